// File: rtl/axil_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_req_queue_if
// Description : AXI4-Lite AW/W/AR request channels plus the head-of-queue
//               view and pop handshake used by the downstream bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_req_queue_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int DEPTH     = 4
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [ADDRWIDTH-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;

    logic [DATAWIDTH-1:0]   wdata;
    logic [DATAWIDTH/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;

    logic [ADDRWIDTH-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;

    logic                   q_write;
    logic [ADDRWIDTH-1:0]   q_addr;
    logic [2:0]             q_prot;
    logic [DATAWIDTH-1:0]   q_data;
    logic [DATAWIDTH/8-1:0] q_strb;
    logic                   pop;
    logic                   empty;
    logic                   full;
    logic [c_CNT_W-1:0]     count;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        input  araddr, arprot, arvalid,
        output arready,
        output q_write, q_addr, q_prot, q_data, q_strb,
        input  pop,
        output empty, full, count
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        output araddr, arprot, arvalid,
        input  arready,
        input  q_write, q_addr, q_prot, q_data, q_strb,
        output pop,
        input  empty, full, count
    );
endinterface
`default_nettype wire

// File: rtl/axil_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : axil_req_queue
// Description : Accepts AXI4-Lite write (AW+W) and read (AR) requests,
//               arbitrates one per cycle into a circular FWFT request queue.
//               Optional macro REQ_QUEUE_RR_ARB_EN selects round-robin
//               arbitration instead of fixed write priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_req_queue #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    axil_req_queue_if.slave   bus
);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_STRB_W = DATAWIDTH / 8;

    // AW / W hold registers
    logic                   r_aw_valid;
    logic [ADDRWIDTH-1:0]   r_aw_addr;
    logic [2:0]             r_aw_prot;
    logic                   r_w_valid;
    logic [DATAWIDTH-1:0]   r_w_data;
    logic [c_STRB_W-1:0]    r_w_strb;

    // Queue storage and bookkeeping
    logic                   r_mem_write [DEPTH];
    logic [ADDRWIDTH-1:0]   r_mem_addr  [DEPTH];
    logic [2:0]             r_mem_prot  [DEPTH];
    logic [DATAWIDTH-1:0]   r_mem_data  [DEPTH];
    logic [c_STRB_W-1:0]    r_mem_strb  [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

`ifdef REQ_QUEUE_RR_ARB_EN
    logic                   r_last_grant_wr;
`endif

    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_cand;
    logic                   w_rd_cand;
    logic                   w_grant_wr;
    logic                   w_grant_rd;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_awready;
    logic                   w_wready;
    logic                   w_aw_fire;
    logic                   w_w_fire;
    logic [ADDRWIDTH-1:0]   w_push_addr;
    logic [2:0]             w_push_prot;
    logic [DATAWIDTH-1:0]   w_push_data;
    logic [c_STRB_W-1:0]    w_push_strb;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_wr_cand = r_aw_valid & r_w_valid;
    assign w_rd_cand = bus.arvalid;

    assign w_awready = ~rst & ~r_aw_valid;
    assign w_wready  = ~rst & ~r_w_valid;
    assign w_aw_fire = bus.awvalid & w_awready;
    assign w_w_fire  = bus.wvalid & w_wready;

    // Grants are gated by reset and by full; a same-cycle pop never frees a slot early.
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (!rst && !w_full) begin
            if (w_wr_cand && w_rd_cand) begin
`ifdef REQ_QUEUE_RR_ARB_EN
                w_grant_wr = ~r_last_grant_wr;
                w_grant_rd = r_last_grant_wr;
`else
                w_grant_wr = 1'b1;
`endif
            end else begin
                w_grant_wr = w_wr_cand;
                w_grant_rd = w_rd_cand;
            end
        end
    end

    assign w_push      = w_grant_wr | w_grant_rd;
    assign w_pop       = ~rst & bus.pop & ~w_empty;
    assign w_push_addr = w_grant_wr ? r_aw_addr : bus.araddr;
    assign w_push_prot = w_grant_wr ? r_aw_prot : bus.arprot;
    assign w_push_data = w_grant_wr ? r_w_data  : '0;
    assign w_push_strb = w_grant_wr ? r_w_strb  : '0;

    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.arready = w_grant_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_aw_addr  <= '0;
            r_aw_prot  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
        end else begin
            // A write grant needs both holds valid, so it never collides with a capture.
            if (w_grant_wr) begin
                r_aw_valid <= 1'b0;
                r_w_valid  <= 1'b0;
            end
            if (w_aw_fire) begin
                r_aw_valid <= 1'b1;
                r_aw_addr  <= bus.awaddr;
                r_aw_prot  <= bus.awprot;
            end
            if (w_w_fire) begin
                r_w_valid  <= 1'b1;
                r_w_data   <= bus.wdata;
                r_w_strb   <= bus.wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_write[r_wr_ptr] <= w_grant_wr;
            r_mem_addr[r_wr_ptr]  <= w_push_addr;
            r_mem_prot[r_wr_ptr]  <= w_push_prot;
            r_mem_data[r_wr_ptr]  <= w_push_data;
            r_mem_strb[r_wr_ptr]  <= w_push_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef REQ_QUEUE_RR_ARB_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant_wr <= 1'b0;
        end else if (w_push) begin
            r_last_grant_wr <= w_grant_wr;
        end
    end
`endif

    // Head view is forced to zero while empty so stale storage never leaks out.
    assign bus.q_write = w_empty ? 1'b0 : r_mem_write[r_rd_ptr];
    assign bus.q_addr  = w_empty ? '0   : r_mem_addr[r_rd_ptr];
    assign bus.q_prot  = w_empty ? '0   : r_mem_prot[r_rd_ptr];
    assign bus.q_data  = w_empty ? '0   : r_mem_data[r_rd_ptr];
    assign bus.q_strb  = w_empty ? '0   : r_mem_strb[r_rd_ptr];
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.count   = r_count;
endmodule
`default_nettype wire
